// File: rtl/mat_mul_if.sv
// mat_mul_if
//   Handshake and matrix bus for the sequential matrix multiplier.
//   Matrices are ORDER*ORDER signed elements, row-major (index row*ORDER+col).
// Signals
//   i_start     start request (master -> slave)
//   i_mat_a     left operand  (master -> slave)
//   i_mat_b     right operand (master -> slave)
//   o_mat       product, registered (slave -> master)
//   o_busy      high while the multiplier is running (slave -> master)
//   o_done      one-cycle completion pulse (slave -> master)
//   o_overflow  sticky saturation flag (slave -> master)
// Modports
//   master  drives the operands and start (testbench / upstream block)
//   slave   the multiplier itself
interface mat_mul_if #(
  parameter int ORDER = 3,
  parameter int WIDTH = 16
);
  logic                    i_start;
  logic signed [WIDTH-1:0] i_mat_a [ORDER*ORDER];
  logic signed [WIDTH-1:0] i_mat_b [ORDER*ORDER];
  logic signed [WIDTH-1:0] o_mat   [ORDER*ORDER];
  logic                    o_busy;
  logic                    o_done;
  logic                    o_overflow;

  modport master (
    output i_start, i_mat_a, i_mat_b,
    input  o_mat, o_busy, o_done, o_overflow
  );

  modport slave (
    input  i_start, i_mat_a, i_mat_b,
    output o_mat, o_busy, o_done, o_overflow
  );
endinterface

// File: rtl/mat_mul.sv
// mat_mul
//   Sequential signed fixed-point square-matrix multiplier: o_mat = i_mat_a * i_mat_b.
//   Elements are Q(WIDTH-QBITS).QBITS two's complement. One multiply-accumulate
//   per cycle: each output element takes ORDER MAC cycles plus one STORE cycle,
//   so o_done pulses ORDER*ORDER*(ORDER+1) edges after the accepted start edge.
// Ports
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset; aborts a run and clears o_mat
//   bus      mat_mul_if.slave: i_start, i_mat_a, i_mat_b, o_mat, o_busy,
//            o_done, o_overflow
// Configuration
//   MAT_MUL_SATURATE_EN  defined: results clamp to the WIDTH range and set the
//                        sticky o_overflow flag. Undefined: results wrap to the
//                        low WIDTH bits and o_overflow is tied low.
module mat_mul #(
  parameter int ORDER = 3,
  parameter int WIDTH = 16,
  parameter int QBITS = 8
) (
  input logic     i_clk,
  input logic     i_rst_n,
  mat_mul_if.slave bus
);

  localparam int N     = ORDER * ORDER;
  localparam int IW    = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam int NW    = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * WIDTH + $clog2(ORDER);
  localparam logic [IW-1:0] LAST = IW'(ORDER - 1);

  typedef enum logic [1:0] {IDLE, MAC, STORE} state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0]   a_reg [N];
  logic signed [WIDTH-1:0]   b_reg [N];
  logic        [IW-1:0]      row, col, k;
  logic signed [ACC_W-1:0]   acc;
  logic signed [2*WIDTH-1:0] prod;
  logic        [NW-1:0]      a_idx, b_idx, o_idx;
  logic signed [WIDTH-1:0]   elem;
  logic                      last_elem;
  logic                      done_q;
  logic                      accept;

  assign accept    = (state == IDLE) && bus.i_start;
  assign last_elem = (row == LAST) && (col == LAST);

  // Element addressing for the current MAC term and the element being stored
  always_comb begin
    a_idx = NW'(row) * NW'(ORDER) + NW'(k);
    b_idx = NW'(k) * NW'(ORDER) + NW'(col);
    o_idx = NW'(row) * NW'(ORDER) + NW'(col);
    prod  = a_reg[a_idx] * b_reg[b_idx];
  end

`ifdef MAT_MUL_SATURATE_EN
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  logic                    clamp;
  logic                    ovf_q;

  // The value fits in WIDTH bits only when every bit above the result's sign
  // bit matches it; otherwise clamp toward the sign of the accumulator.
  always_comb begin
    shifted = acc >>> QBITS;
    clamp   = (shifted[ACC_W-1:WIDTH-1] != {(ACC_W-WIDTH+1){shifted[ACC_W-1]}});
    if (clamp) begin
      elem = shifted[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      elem = shifted[WIDTH-1:0];
    end
  end

  // Sticky overflow: cleared by an accepted start, set by any clamped store
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (state == STORE && clamp) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.o_overflow = ovf_q;
`else
  // Floor shift then two's-complement wrap to WIDTH bits
  always_comb begin
    elem = WIDTH'(acc >>> QBITS);
  end

  assign bus.o_overflow = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.i_start) state_next = MAC;
      MAC:     if (k == LAST) state_next = STORE;
      STORE:   state_next = last_elem ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.o_busy = (state != IDLE);
  end

  assign bus.o_done = done_q;

  // Operand capture, accumulation and element-by-element result writeback
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) begin
        a_reg[i]   <= '0;
        b_reg[i]   <= '0;
        bus.o_mat[i] <= '0;
      end
      row    <= '0;
      col    <= '0;
      k      <= '0;
      acc    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == STORE) && last_elem;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            for (int i = 0; i < N; i++) begin
              a_reg[i] <= bus.i_mat_a[i];
              b_reg[i] <= bus.i_mat_b[i];
            end
            row <= '0;
            col <= '0;
            k   <= '0;
            acc <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          k   <= (k == LAST) ? '0 : k + 1'b1;
        end
        STORE: begin
          bus.o_mat[o_idx] <= elem;
          acc <= '0;
          if (col == LAST) begin
            col <= '0;
            row <= (row == LAST) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mul.sv
// tb_mat_mul
//   Directed self-checking bench for mat_mul (ORDER=3, WIDTH=16, QBITS=8).
//   Covers reset state, identity, scaling, signed products, wrap/saturation,
//   start-while-busy and mid-run reset.
module tb_mat_mul;

  localparam int ORDER = 3;
  localparam int WIDTH = 16;
  localparam int QBITS = 8;
  localparam int N     = ORDER * ORDER;
  localparam int LAT   = N * (ORDER + 1);

  typedef logic signed [WIDTH-1:0] mat_t [N];

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  int total = 0;
  int bad   = 0;

  mat_mul_if #(.ORDER(ORDER), .WIDTH(WIDTH)) bus ();

  mat_mul #(.ORDER(ORDER), .WIDTH(WIDTH), .QBITS(QBITS)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  mat_t zeroM  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  mat_t identM = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
  mat_t seqB   = '{256, 512, 768, 1024, 1280, 1536, 1792, 2048, 2304};
  mat_t diag2  = '{512, 0, 0, 0, 512, 0, 0, 0, 512};
  mat_t diagH  = '{128, 0, 0, 0, 128, 0, 0, 0, 128};
  mat_t diagN  = '{-384, 0, 0, 0, -384, 0, 0, 0, -384};
  mat_t diagM  = '{-768, 0, 0, 0, -768, 0, 0, 0, -768};
  mat_t diagC  = '{25600, 0, 0, 0, 25600, 0, 0, 0, 25600};
`ifdef MAT_MUL_SATURATE_EN
  mat_t bigExp = '{32767, 0, 0, 0, 32767, 0, 0, 0, 32767};
  localparam int BIG_OVF = 1;
`else
  mat_t bigExp = '{4096, 0, 0, 0, 4096, 0, 0, 0, 4096};
  localparam int BIG_OVF = 0;
`endif

  int  doneEdge;
  bit  busyOk;
  bit  doneFell;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkMatrix(input string tag, input mat_t expected);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("%s[%0d]", tag, i), int'(bus.o_mat[i]), int'(expected[i]));
    end
  endtask

  // Present operands and pulse i_start across one rising edge (the start edge)
  task automatic applyStimulus(input mat_t a, input mat_t b);
    @(negedge i_clk);
    for (int i = 0; i < N; i++) begin
      bus.i_mat_a[i] = a[i];
      bus.i_mat_b[i] = b[i];
    end
    bus.i_start = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  // Run one product; optionally re-assert start with other operands at glitchEdge
  task automatic runProduct(input mat_t a, input mat_t b, input int glitchEdge,
                            input mat_t ga, input mat_t gb,
                            output int dEdge, output bit bOk, output bit dFell);
    applyStimulus(a, b);
    dEdge = -1;
    bOk   = bus.o_busy;
    for (int e = 1; e <= 60 && dEdge < 0; e++) begin
      @(posedge i_clk);
      #1;
      if (e == glitchEdge) bus.i_start = 1'b0;
      if (bus.o_done) begin
        dEdge = e;
        if (bus.o_busy) bOk = 1'b0;
      end else if (!bus.o_busy) begin
        bOk = 1'b0;
      end
      if (e == glitchEdge - 1) begin
        bus.i_start = 1'b1;
        for (int i = 0; i < N; i++) begin
          bus.i_mat_a[i] = ga[i];
          bus.i_mat_b[i] = gb[i];
        end
      end
    end
    @(posedge i_clk);
    #1;
    dFell = !bus.o_done;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.i_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.i_mat_a[i] = '0;
      bus.i_mat_b[i] = '0;
    end

    // Reset state
    #12;
    checkMatrix("reset_mat", zeroM);
    checkOutput("reset_busy", int'(bus.o_busy), 0);
    checkOutput("reset_done", int'(bus.o_done), 0);
    checkOutput("reset_ovf", int'(bus.o_overflow), 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // 1: identity times sequence, with latency and busy window
    runProduct(identM, seqB, 0, zeroM, zeroM, doneEdge, busyOk, doneFell);
    checkOutput("t1_done_edge", doneEdge, LAT);
    checkOutput("t1_busy_window", int'(busyOk), 1);
    checkOutput("t1_done_fall", int'(doneFell), 1);
    checkMatrix("t1_mat", seqB);
    checkOutput("t1_ovf", int'(bus.o_overflow), 0);

    // 2: 2.0 * 0.5
    runProduct(diag2, diagH, 0, zeroM, zeroM, doneEdge, busyOk, doneFell);
    checkOutput("t2_done_edge", doneEdge, LAT);
    checkMatrix("t2_mat", identM);

    // 3: -1.5 * 2.0
    runProduct(diagN, diag2, 0, zeroM, zeroM, doneEdge, busyOk, doneFell);
    checkOutput("t3_done_edge", doneEdge, LAT);
    checkMatrix("t3_mat", diagM);

    // 4: 100.0 * 100.0 exceeds the Q8.8 range
    runProduct(diagC, diagC, 0, zeroM, zeroM, doneEdge, busyOk, doneFell);
    checkOutput("t4_done_edge", doneEdge, LAT);
    checkMatrix("t4_mat", bigExp);
    checkOutput("t4_ovf", int'(bus.o_overflow), BIG_OVF);

    // 5: start re-asserted at edge 10 with new operands is ignored
    runProduct(identM, seqB, 10, diag2, diagH, doneEdge, busyOk, doneFell);
    checkOutput("t5_done_edge", doneEdge, LAT);
    checkOutput("t5_busy_window", int'(busyOk), 1);
    checkOutput("t5_done_fall", int'(doneFell), 1);
    checkMatrix("t5_mat", seqB);
    checkOutput("t5_ovf_cleared", int'(bus.o_overflow), 0);

    // 6: reset near edge 20 of a run, then a clean run
    applyStimulus(identM, seqB);
    repeat (19) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkMatrix("t6_rst_mat", zeroM);
    checkOutput("t6_rst_busy", int'(bus.o_busy), 0);
    checkOutput("t6_rst_done", int'(bus.o_done), 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    runProduct(diag2, diagH, 0, zeroM, zeroM, doneEdge, busyOk, doneFell);
    checkOutput("t6_done_edge", doneEdge, LAT);
    checkOutput("t6_busy_window", int'(busyOk), 1);
    checkMatrix("t6_mat", identM);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
